ca_run_ctrl: RTL and testbench

CA_RUN_CTRL -- requirements
Module: ca_run_ctrl

---
 rtl/ca_pkg.sv | 16 +
 rtl/ca_next.sv | 26 ++
 rtl/ca_run_ctrl.sv | 147 ++++++++++++++
 tb/tb_ca_run_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// ca_pkg -- shared definitions for the cellular-automaton run controller.
//   CA_WIDTH   : default number of cells in the ring
//   CA_CNT_W   : default width of the step count / generation counter
//   ca_state_e : run-controller FSM state encoding
package ca_pkg;

  localparam int CA_WIDTH = 20;
  localparam int CA_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } ca_state_e;

endpackage

// File: rtl/ca_next.sv
// ca_next -- one generation of an elementary (Wolfram-rule) cellular
// automaton on a ring of WIDTH cells. Purely combinational.
//   rule [7:0]       : bit k is the next cell value for neighbourhood k
//   cur  [WIDTH-1:0] : current generation
//   nxt  [WIDTH-1:0] : next generation
// Neighbourhood of cell i is {cur[i+1], cur[i], cur[i-1]} with the indices
// wrapping around the ring, so cell i+1 is the "left" (most significant) bit.
module ca_next
  import ca_pkg::*;
#(
  parameter int WIDTH = CA_WIDTH
) (
  input  logic [7:0]       rule,
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    localparam int LEFT  = (i + 1) % WIDTH;
    localparam int RIGHT = (i + WIDTH - 1) % WIDTH;
    logic [2:0] nbh;
    assign nbh    = {cur[LEFT], cur[i], cur[RIGHT]};
    assign nxt[i] = rule[nbh];
  end

endmodule

// File: rtl/ca_run_ctrl.sv
// ca_run_ctrl -- runs an elementary cellular automaton for a configured
// number of generations and streams every generation out.
//   clk, res            : clock, asynchronous active-high reset
//   cfg_valid/cfg_ready : run configuration handshake
//   cfg_rule/init/steps : rule number, generation 0, generations to advance
//   cfg_stop_fixed      : end the run early when next generation == current
//   abort               : cancel the current run (no done pulse)
//   out_valid/out_ready : generation output handshake
//   out_data/out_gen    : current generation and its index
//   done                : one-cycle pulse when a run completes
//   done_gen/done_fixed : index of the last emitted generation, fixed-point exit
//   dbg_state           : FSM state, for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. While out_valid is high and out_ready is low, out_data and
// out_gen are held stable. cfg_valid is only looked at in IDLE.
module ca_run_ctrl
  import ca_pkg::*;
#(
  parameter int WIDTH = CA_WIDTH,
  parameter int CNT_W = CA_CNT_W
) (
  input  logic             clk,
  input  logic             res,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [7:0]       cfg_rule,
  input  logic [WIDTH-1:0] cfg_init,
  input  logic [CNT_W-1:0] cfg_steps,
  input  logic             cfg_stop_fixed,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_gen,
  output logic             done,
  output logic [CNT_W-1:0] done_gen,
  output logic             done_fixed,
  output logic [1:0]       dbg_state
);

  ca_state_e        fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0] gen_q, gen_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [7:0]       rule_q, rule_d;
  logic             stop_fixed_q, stop_fixed_d;
  logic [CNT_W-1:0] done_gen_q, done_gen_d;
  logic             done_fixed_q, done_fixed_d;

  logic [WIDTH-1:0] next_state;
  logic             is_fixed;

  ca_next #(.WIDTH(WIDTH)) u_next (
    .rule (rule_q),
    .cur  (state_q),
    .nxt  (next_state)
  );

  // Fixed-point exit reuses the single next-generation evaluation above.
  assign is_fixed = stop_fixed_q && (next_state == state_q);

  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    gen_d        = gen_q;
    rem_d        = rem_q;
    rule_d       = rule_q;
    stop_fixed_d = stop_fixed_q;
    done_gen_d   = done_gen_q;
    done_fixed_d = done_fixed_q;
    cfg_ready    = 1'b0;
    out_valid    = 1'b0;
    done         = 1'b0;

    case (fsm_q)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          rule_d       = cfg_rule;
          stop_fixed_d = cfg_stop_fixed;
          state_d      = cfg_init;
          rem_d        = cfg_steps;
          gen_d        = '0;
          fsm_d        = ST_EMIT;
        end
      end

      ST_EMIT: begin
        out_valid = 1'b1;
        // abort wins over an accepted generation in the same cycle
        if (abort) begin
          fsm_d = ST_IDLE;
        end else if (out_ready) begin
          // A fixed point coinciding with the last step still reports fixed.
          if ((rem_q == '0) || is_fixed) begin
            fsm_d        = ST_DONE;
            done_gen_d   = gen_q;
            done_fixed_d = is_fixed;
          end else begin
            state_d = next_state;
            gen_d   = gen_q + 1'b1;
            rem_d   = rem_q - 1'b1;
          end
        end
      end

      ST_DONE: begin
        done  = ~abort;
        fsm_d = ST_IDLE;
      end

      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      fsm_q        <= ST_IDLE;
      state_q      <= '0;
      gen_q        <= '0;
      rem_q        <= '0;
      rule_q       <= '0;
      stop_fixed_q <= 1'b0;
      done_gen_q   <= '0;
      done_fixed_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      gen_q        <= gen_d;
      rem_q        <= rem_d;
      rule_q       <= rule_d;
      stop_fixed_q <= stop_fixed_d;
      done_gen_q   <= done_gen_d;
      done_fixed_q <= done_fixed_d;
    end
  end

  assign out_data   = state_q;
  assign out_gen    = gen_q;
  assign done_gen   = done_gen_q;
  assign done_fixed = done_fixed_q;
  assign dbg_state  = fsm_q;

endmodule

// File: tb/tb_ca_run_ctrl.sv
// tb_ca_run_ctrl -- self-checking bench for ca_run_ctrl. Expected generations
// and done results are queued when a run is configured and compared as the
// DUT hands them out.
module tb_ca_run_ctrl;

  localparam int W  = 20;
  localparam int CW = 16;
  localparam int EW = CW + W;

  // clock / reset
  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [7:0]    cfg_rule = '0;
  logic [W-1:0]  cfg_init = '0;
  logic [CW-1:0] cfg_steps = '0;
  logic          cfg_stop_fixed = 1'b0;
  logic          abort = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_gen;
  logic          done;
  logic [CW-1:0] done_gen;
  logic          done_fixed;
  logic [1:0]    dbg_state;

  ca_run_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk            (clk),
    .res            (res),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_rule       (cfg_rule),
    .cfg_init       (cfg_init),
    .cfg_steps      (cfg_steps),
    .cfg_stop_fixed (cfg_stop_fixed),
    .abort          (abort),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_gen        (out_gen),
    .done           (done),
    .done_gen       (done_gen),
    .done_fixed     (done_fixed),
    .dbg_state      (dbg_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic [CW:0]   done_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference: one elementary-CA generation on a ring
  function automatic logic [W-1:0] ca_step(input logic [7:0] r, input logic [W-1:0] s);
    logic [W-1:0] n;
    logic [2:0]   k;
    n = '0;
    for (int i = 0; i < W; i++) begin
      k    = {s[(i + 1) % W], s[i], s[(i + W - 1) % W]};
      n[i] = r[k];
    end
    return n;
  endfunction

  // Queue the expected outputs of a run. limit >= 0 keeps only the first
  // `limit` generations and no done entry (run is killed before finishing).
  task automatic model_run(input logic [7:0] r, input logic [W-1:0] init,
                           input logic [CW-1:0] steps, input logic sf, input int limit);
    logic [W-1:0]  s, nx;
    logic [CW-1:0] g;
    s = init;
    g = '0;
    forever begin
      if (limit >= 0 && int'(g) >= limit) return;
      exp_q.push_back({g, s});
      nx = ca_step(r, s);
      if (sf && nx == s) begin
        done_q.push_back({g, 1'b1});
        return;
      end
      if (g == steps) begin
        done_q.push_back({g, 1'b0});
        return;
      end
      s = nx;
      g = g + 1'b1;
    end
  endtask

  task automatic push_out(input logic [CW-1:0] g, input logic [W-1:0] d);
    exp_q.push_back({g, d});
  endtask

  // monitor: compare every accepted generation and every done pulse
  always @(negedge clk) begin
    if (!res) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_extra", 1, 0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("out_gen", out_gen, e[EW-1:W]);
          check("out_data", out_data, e[W-1:0]);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("done_extra", 1, 0);
        end else begin
          logic [CW:0] d;
          d = done_q.pop_front();
          check("done_gen", done_gen, d[CW:1]);
          check("done_fixed", done_fixed, d[0]);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (cfg_ready) break;
      @(posedge clk); #1;
    end
    check("idle_reached", cfg_ready, 1);
  endtask

  task automatic wait_gen(input logic [CW-1:0] k, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (out_valid && out_gen == k) break;
      @(posedge clk); #1;
    end
    check("gen_reached", out_valid && (out_gen == k), 1);
  endtask

  task automatic start_run(input logic [7:0] r, input logic [W-1:0] init,
                           input logic [CW-1:0] steps, input logic sf);
    wait_idle(200);
    cfg_rule       = r;
    cfg_init       = init;
    cfg_steps      = steps;
    cfg_stop_fixed = sf;
    cfg_valid      = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("first_valid", out_valid, 1);
    check("first_gen", out_gen, 0);
    check("busy_not_ready", cfg_ready, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_gen"}, out_gen, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_done_gen"}, done_gen, 0);
    check({tag, "_done_fixed"}, done_fixed, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]    r;
    logic [W-1:0]  init;
    logic [CW-1:0] steps;
    logic          sf;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    res = 1'b0;
    @(posedge clk); #1;

    // rule 184 single particle, 3 steps, consumer always ready
    out_ready = 1'b1;
    push_out(16'd0, 20'h00001);
    push_out(16'd1, 20'h80000);
    push_out(16'd2, 20'h40000);
    push_out(16'd3, 20'h20000);
    done_q.push_back({16'd3, 1'b0});
    start_run(8'd184, 20'h00001, 16'd3, 1'b0);
    wait_idle(50);

    // identity rule with stop_fixed: only generation 0, fixed exit
    push_out(16'd0, 20'h0F0F0);
    done_q.push_back({16'd0, 1'b1});
    start_run(8'd204, 20'h0F0F0, 16'd10, 1'b1);
    wait_idle(50);

    // back-pressure after gen 1: output must hold
    push_out(16'd0, 20'h00001);
    push_out(16'd1, 20'h80000);
    push_out(16'd2, 20'h40000);
    push_out(16'd3, 20'h20000);
    done_q.push_back({16'd3, 1'b0});
    start_run(8'd184, 20'h00001, 16'd3, 1'b0);
    wait_gen(16'd1, 10);
    out_ready = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 20'h80000);
      check("stall_gen", out_gen, 1);
    end
    out_ready = 1'b1;
    wait_idle(50);

    // abort at gen 5 of a long rule-90 run
    model_run(8'd90, 20'h00400, 16'd100, 1'b0, 5);
    start_run(8'd90, 20'h00400, 16'd100, 1'b0);
    wait_gen(16'd5, 20);
    out_ready = 1'b0;
    abort     = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_ready", cfg_ready, 1);
    check("abort_done", done, 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // reset in the middle of a run, then a zero-step run
    model_run(8'd90, 20'h12345, 16'd50, 1'b0, 3);
    start_run(8'd90, 20'h12345, 16'd50, 1'b0);
    wait_gen(16'd3, 20);
    out_ready = 1'b0;
    res       = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(posedge clk);
    @(negedge clk);
    res       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    model_run(8'd30, 20'h00100, 16'd0, 1'b0, -1);
    start_run(8'd30, 20'h00100, 16'd0, 1'b0);
    wait_idle(50);

    // cfg_valid held through a run, second config taken right after DONE
    wait_idle(50);
    cfg_rule       = 8'd90;
    cfg_init       = 20'h00010;
    cfg_steps      = 16'd2;
    cfg_stop_fixed = 1'b0;
    cfg_valid      = 1'b1;
    model_run(8'd90, 20'h00010, 16'd2, 1'b0, -1);
    @(posedge clk); #1;
    check("hold_a_busy", cfg_ready, 0);
    cfg_rule  = 8'd110;
    cfg_init  = 20'h80001;
    cfg_steps = 16'd3;
    model_run(8'd110, 20'h80001, 16'd3, 1'b0, -1);
    for (int i = 0; i < 20; i++) begin
      if (cfg_ready) break;
      @(posedge clk); #1;
    end
    check("hold_idle_reached", cfg_ready, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("b2b_first_valid", out_valid, 1);
    check("b2b_first_gen", out_gen, 0);
    wait_idle(50);

    // random runs with a randomly stalling consumer
    for (int t = 0; t < 8; t++) begin
      r     = (t == 0) ? 8'd204 : (t == 1) ? 8'd0 : 8'($urandom_range(0, 255));
      init  = W'($urandom);
      steps = CW'($urandom_range(0, 12));
      sf    = 1'($urandom_range(0, 1));
      model_run(r, init, steps, sf, -1);
      start_run(r, init, steps, sf);
      for (int i = 0; i < 200; i++) begin
        if (cfg_ready) break;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      check("rand_idle_reached", cfg_ready, 1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_empty", exp_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
